// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C receive path.
package i2c_pkg;

  localparam int unsigned I2C_DW = 8;

  // One framed byte as stored in the receive FIFO: data in the upper bits, last in bit 0.
  typedef struct packed {
    logic [I2C_DW-1:0] data;
    logic              last;
  } i2c_rx_entry_t;

endpackage

// File: rtl/i2c_sync_fifo.sv
// Generic synchronous FIFO with occupancy count. Pushes that do not fit are ignored
// (a full FIFO only accepts a push in the same cycle as a pop).
module i2c_sync_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 9,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  // Qualify requests against occupancy; full+pop frees the slot being written.
  always_comb begin
    do_pop  = pop & ~empty;
    do_push = push & (~full | do_pop);
  end

  assign count = count_q;
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign rdata = mem[rd_ptr_q];

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_q] <= wdata;
    end
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/i2c_rx_frame_fifo.sv
// Frames bytes from the I2C slave into transactions and buffers them for the host.
// A single staging register holds the newest byte until the next byte (not last)
// or a STOP (last) decides how it is pushed.
module i2c_rx_frame_fifo
  import i2c_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned DW    = I2C_DW,
  localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] rx_data,
  input  logic          rx_valid,
  input  logic          rx_stop,
  output logic [DW-1:0] m_data,
  output logic          m_last,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          overflow,
  input  logic          ovf_clr
);

  logic          hold_valid_q;
  logic [DW-1:0] hold_data_q;
  logic          overflow_q;
  logic          push_req, push_ok, pop, empty;
  logic [DW:0]   wr_entry, rd_entry;

  // The staged byte leaves whenever a newer byte or a STOP arrives; STOP marks it last.
  // With both strobes together the STOP closes the older transaction.
  always_comb begin
    push_req = hold_valid_q & (rx_valid | rx_stop);
    wr_entry = {hold_data_q, rx_stop};
    pop      = m_valid & m_ready;
    push_ok  = push_req & (~full | pop);
  end

  i2c_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DW + 1)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_ok),
    .wdata (wr_entry),
    .pop   (pop),
    .rdata (rd_entry),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign m_valid  = ~empty;
  assign m_data   = rd_entry[DW:1];
  assign m_last   = rd_entry[0];
  assign overflow = overflow_q;

  // Staging register: a new byte always loads; a lone STOP empties it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
    end else if (rx_valid) begin
      hold_valid_q <= 1'b1;
      hold_data_q  <= rx_data;
    end else if (rx_stop) begin
      hold_valid_q <= 1'b0;
    end
  end

  // Sticky drop flag; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow_q <= 1'b0;
    end else if (push_req && !push_ok) begin
      overflow_q <= 1'b1;
    end else if (ovf_clr) begin
      overflow_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_i2c_rx_frame_fifo.sv
// Scoreboard bench for i2c_rx_frame_fifo: stimulus queues hand-computed entries,
// a negedge monitor checks every accepted head against the queue.
module tb_i2c_rx_frame_fifo;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned DW    = 8;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] rx_data = '0;
  logic          rx_valid = 1'b0;
  logic          rx_stop = 1'b0;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [CW-1:0] count;
  logic          full;
  logic          overflow;
  logic          ovf_clr = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW:0] sb [$];  // {data, last}

  i2c_rx_frame_fifo #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_stop  (rx_stop),
    .m_data   (m_data),
    .m_last   (m_last),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .count    (count),
    .full     (full),
    .overflow (overflow),
    .ovf_clr  (ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Apply one cycle of inputs just after a rising edge.
  task automatic drive(input logic v, input logic [DW-1:0] d, input logic s,
                       input logic r, input logic c);
    @(posedge clk);
    #1;
    rx_valid = v;
    rx_data  = d;
    rx_stop  = s;
    m_ready  = r;
    ovf_clr  = c;
  endtask

  task automatic idle(input logic r, input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, r, 1'b0);
  endtask

  task automatic expect_entry(input logic [DW-1:0] d, input logic l);
    sb.push_back({d, l});
  endtask

  // Monitor: every head accepted by the consumer must be the next expected entry.
  always @(negedge clk) begin
    if (rst && m_valid && m_ready) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_entry: got data=0x%0h last=%0b, none expected", m_data, m_last);
      end else begin
        logic [DW:0] e;
        e = sb.pop_front();
        if ({m_data, m_last} != e) begin
          n_fail++;
          $display("FAIL entry: got data=0x%0h last=%0b expected data=0x%0h last=%0b",
                   m_data, m_last, e[DW:1], e[0]);
        end
      end
    end
  end

  initial begin
    // Reset state
    #2;
    check("rst_count", int'(count), 0);
    check("rst_valid", int'(m_valid), 0);
    check("rst_full", int'(full), 0);
    check("rst_ovf", int'(overflow), 0);
    #20;
    rst = 1'b1;

    // Two-byte frame with a ready consumer
    expect_entry(8'hA5, 1'b0);
    expect_entry(8'h3C, 1'b1);
    drive(1'b1, 8'hA5, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 8'h3C, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    idle(1'b1, 4);
    @(negedge clk);
    check("t1_count", int'(count), 0);
    check("t1_valid", int'(m_valid), 0);

    // STOP with nothing staged produces no entry
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    idle(1'b0, 3);
    @(negedge clk);
    check("t2_valid", int'(m_valid), 0);
    check("t2_count", int'(count), 0);

    // Nine 2-byte frames into a stalled FIFO: only the first four frames fit
    for (int f = 0; f < 4; f++) begin
      expect_entry(8'(f * 16), 1'b0);
      expect_entry(8'(f * 16 + 1), 1'b1);
    end
    for (int f = 0; f < 9; f++) begin
      drive(1'b1, 8'(f * 16), 1'b0, 1'b0, 1'b0);
      drive(1'b1, 8'(f * 16 + 1), 1'b0, 1'b0, 1'b0);
      drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end
    idle(1'b0, 1);
    @(negedge clk);
    check("t3_count", int'(count), 8);
    check("t3_full", int'(full), 1);
    check("t3_ovf", int'(overflow), 1);
    check("t3_head_data", int'(m_data), 8'h00);
    check("t3_head_last", int'(m_last), 0);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    idle(1'b0, 1);
    @(negedge clk);
    check("t3_ovf_clr", int'(overflow), 0);

    // Full FIFO: push and pop in the same cycle
    expect_entry(8'hE1, 1'b0);
    expect_entry(8'hE2, 1'b1);
    drive(1'b1, 8'hE1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'hE2, 1'b0, 1'b1, 1'b0);
    idle(1'b0, 1);
    @(negedge clk);
    check("t4_count", int'(count), 8);
    check("t4_ovf", int'(overflow), 0);
    check("t4_head_data", int'(m_data), 8'h01);
    check("t4_head_last", int'(m_last), 1);
    drive(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    idle(1'b1, 12);
    @(negedge clk);
    check("t4_drain_count", int'(count), 0);
    check("t4_drain_ovf", int'(overflow), 0);

    // STOP and new byte in the same cycle
    expect_entry(8'h11, 1'b1);
    expect_entry(8'h77, 1'b1);
    drive(1'b1, 8'h11, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 8'h77, 1'b1, 1'b1, 1'b0);
    idle(1'b1, 3);
    @(negedge clk);
    check("t5_mid_count", int'(count), 0);
    drive(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    idle(1'b1, 3);
    @(negedge clk);
    check("t5_count", int'(count), 0);

    // Asynchronous reset mid-frame discards FIFO and staged byte
    drive(1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'h02, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'h03, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'h04, 1'b0, 1'b0, 1'b0);
    idle(1'b0, 1);
    @(negedge clk);
    check("t6_pre_count", int'(count), 3);
    #2;
    rst = 1'b0;
    #1;
    check("t6_rst_count", int'(count), 0);
    check("t6_rst_valid", int'(m_valid), 0);
    check("t6_rst_ovf", int'(overflow), 0);
    @(negedge clk);
    rst = 1'b1;
    expect_entry(8'hC1, 1'b0);
    expect_entry(8'hC2, 1'b1);
    drive(1'b1, 8'hC1, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 8'hC2, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    idle(1'b1, 4);
    @(negedge clk);
    check("t6_post_count", int'(count), 0);

    // Every queued entry must have been seen
    check("sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
